feature_vector_tx: RTL and testbench
====================================

FEATURE_VECTOR_TX -- requirements
Module: feature_vector_tx

Interface
REQ-001 Parameter N_FEAT, default 10, number of features per frame.
REQ-002 Parameter FEAT_W, default 7, feature width (unsigned).
REQ-003 Parameter SLOT, default 4, cycles each feature is held on the bus.
REQ-004 Parameter FRAME_LEN, default 42, cycles feature_vector_output_f is high per frame (N_FEAT*SLOT+2).
REQ-005 Parameter GAP_MIN, default 2, minimum low cycles of feature_vector_output_f between frames.
REQ-006 work_clk  input  1  clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 aer_valid  input  1  one spike event this cycle.
REQ-009 aer_addr  input  4  feature index of the event.
REQ-010 frame_end  input  1  single-cycle pulse closing the accumulation window.
REQ-011 feature_vector_output  output  FEAT_W  current feature value.
REQ-012 feature_vector_output_f  output  1  frame-valid flag.
REQ-013 busy_o  output  1  high from snapshot until gap complete.
REQ-014 overrun_o  output  1  sticky: frame_end arrived while busy.

Function
REQ-015 N_FEAT accumulation counters SHALL increment by 1 on aer_valid with aer_addr < N_FEAT; aer_addr >= N_FEAT SHALL be ignored.
REQ-016 Counters SHALL saturate at 2^FEAT_W-1 (127); no wrap.
REQ-017 frame_end with busy_o low SHALL copy all counters to a snapshot bank and clear counters in the same edge.
REQ-018 aer_valid coincident with accepted frame_end SHALL count into the new window (counter becomes 1, snapshot excludes it).
REQ-019 frame_end with busy_o high SHALL be ignored (no snapshot, no clear), and SHALL set overrun_o.
REQ-020 FSM states: IDLE, SEND, GAP.
REQ-021 IDLE -> SEND on accepted frame_end; busy_o high from the next cycle.
REQ-022 In SEND, feature_vector_output_f SHALL be high for exactly FRAME_LEN consecutive cycles, starting the cycle after frame_end.
REQ-023 Frame cycle index c (0..FRAME_LEN-1): for c < N_FEAT*SLOT output SHALL equal snapshot[c/SLOT]; for the trailing 2 cycles output SHALL be 0.
REQ-024 SEND -> GAP after cycle FRAME_LEN-1; output_f and output SHALL be 0 in GAP.
REQ-025 GAP SHALL last GAP_MIN cycles, then -> IDLE with busy_o low.
REQ-026 Outputs SHALL be registered; output and output_f change only on work_clk edges.
REQ-027 Accumulation SHALL continue uninterrupted during SEND and GAP.
REQ-028 Receiver samples feature k on frame cycle 4k+1; value SHALL be stable over cycles 4k..4k+3.

Reset
REQ-029 On rst_n low: counters and snapshot 0, state IDLE, feature_vector_output 0, feature_vector_output_f 0, busy_o 0, overrun_o 0.
REQ-030 Reset mid-frame SHALL drop output_f immediately (async); no partial frame resumes after release.
REQ-031 overrun_o SHALL clear only on reset.

Structure
REQ-032 Shared package SHALL hold N_FEAT, FEAT_W, SLOT, FRAME_LEN, GAP_MIN and the FSM state encoding, common with the classifier.
REQ-033 One sub-module feature_accum SHALL hold the counters, saturation logic and snapshot bank; top holds FSM and frame counter.

Verification
REQ-034 3 events on addr 0, 5 on addr 9, frame_end -> 42-cycle frame, output 3 on cycles 0-3, 5 on 36-39, 0 on others, then 2 low cycles.
REQ-035 200 events on addr 4, frame_end -> feature 4 = 127 on cycles 16-19.
REQ-036 Events on addr 10 and 15 only, frame_end -> all-zero frame, output_f high 42 cycles.
REQ-037 frame_end at frame cycle 20 -> ignored, overrun_o = 1, next accepted frame_end carries all events since first snapshot.
REQ-038 aer_valid addr 2 with frame_end same cycle -> current frame feature 2 excludes it, next frame feature 2 = 1.
REQ-039 rst_n low at frame cycle 10 -> output_f 0 same cycle, all outputs 0; after release no output_f until new frame_end.

Source files
------------

// File: rtl/feature_vector_tx_pkg.sv
// rtl/feature_vector_tx_pkg.sv - frame geometry and FSM encoding shared with the classifier
package feature_vector_tx_pkg;

  localparam int N_FEAT    = 10;
  localparam int FEAT_W    = 7;
  localparam int SLOT      = 4;
  localparam int FRAME_LEN = N_FEAT * SLOT + 2;
  localparam int GAP_MIN   = 2;
  localparam int AER_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/feature_vector_tx_feature_accum.sv
// rtl/feature_vector_tx_feature_accum.sv - saturating spike counters and snapshot bank
module feature_accum
  import feature_vector_tx_pkg::*;
#(
  parameter int N_FEAT = feature_vector_tx_pkg::N_FEAT,
  parameter int FEAT_W = feature_vector_tx_pkg::FEAT_W,
  parameter int IDX_W  = $clog2(N_FEAT + 1)
) (
  input  logic              work_clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [AER_W-1:0]  i_addr,
  input  logic              i_snap,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [FEAT_W-1:0] o_rd_data
);

  logic [FEAT_W-1:0] r_cnt  [N_FEAT];
  logic [FEAT_W-1:0] r_snap [N_FEAT];
  logic [N_FEAT-1:0] w_hit;

  // Out-of-range addresses simply never match any counter.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      w_hit[i] = i_valid && (i_addr == AER_W'(i));
    end
  end

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FEAT; i++) begin
        r_cnt[i]  <= '0;
        r_snap[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_FEAT; i++) begin
        if (i_snap) begin
          r_snap[i] <= r_cnt[i];
          r_cnt[i]  <= w_hit[i] ? FEAT_W'(1) : '0;
        end else if (w_hit[i] && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // On the snapshot edge the bank is not yet loaded, so feature 0 comes from the live counters.
  always_comb begin
    o_rd_data = '0;
    if (i_rd_idx < IDX_W'(N_FEAT)) begin
      o_rd_data = i_snap ? r_cnt[i_rd_idx] : r_snap[i_rd_idx];
    end
  end

endmodule

// File: rtl/feature_vector_tx.sv
// rtl/feature_vector_tx.sv - serialises the snapshot feature vector as slotted frames
module feature_vector_tx
  import feature_vector_tx_pkg::*;
#(
  parameter int N_FEAT    = feature_vector_tx_pkg::N_FEAT,
  parameter int FEAT_W    = feature_vector_tx_pkg::FEAT_W,
  parameter int SLOT      = feature_vector_tx_pkg::SLOT,
  parameter int FRAME_LEN = feature_vector_tx_pkg::FRAME_LEN,
  parameter int GAP_MIN   = feature_vector_tx_pkg::GAP_MIN
) (
  input  logic              work_clk,
  input  logic              rst_n,
  input  logic              aer_valid,
  input  logic [AER_W-1:0]  aer_addr,
  input  logic              frame_end,
  output logic [FEAT_W-1:0] feature_vector_output,
  output logic              feature_vector_output_f,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int CYC_W   = $clog2(FRAME_LEN);
  localparam int GAP_W   = $clog2(GAP_MIN + 1);
  localparam int IDX_W   = $clog2(N_FEAT + 1);
  localparam int PAY_LEN = N_FEAT * SLOT;

  tx_state_t         r_state;
  logic [CYC_W-1:0]  r_cyc;
  logic [GAP_W-1:0]  r_gap;
  logic [FEAT_W-1:0] r_out;
  logic              r_out_f;
  logic              r_busy;
  logic              r_overrun;

  logic              w_accept;
  logic [CYC_W-1:0]  w_next_cyc;
  logic              w_next_payload;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [FEAT_W-1:0] w_rd_data;

  assign w_accept       = frame_end && (r_state == ST_IDLE);
  assign w_next_cyc     = r_cyc + 1'b1;
  assign w_next_payload = w_next_cyc < CYC_W'(PAY_LEN);
  // Look one cycle ahead so the registered output lands on the right frame cycle.
  assign w_rd_idx       = (r_state == ST_IDLE) ? '0 : IDX_W'(w_next_cyc / CYC_W'(SLOT));

  feature_accum #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W),
    .IDX_W  (IDX_W)
  ) u_accum (
    .work_clk  (work_clk),
    .rst_n     (rst_n),
    .i_valid   (aer_valid),
    .i_addr    (aer_addr),
    .i_snap    (w_accept),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cyc     <= '0;
      r_gap     <= '0;
      r_out     <= '0;
      r_out_f   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (frame_end && r_busy) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (frame_end) begin
            r_state <= ST_SEND;
            r_cyc   <= '0;
            r_out   <= w_rd_data;
            r_out_f <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (r_cyc == CYC_W'(FRAME_LEN - 1)) begin
            r_state <= ST_GAP;
            r_gap   <= '0;
            r_out   <= '0;
            r_out_f <= 1'b0;
          end else begin
            r_cyc <= w_next_cyc;
            r_out <= w_next_payload ? w_rd_data : '0;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_W'(GAP_MIN - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_out   <= '0;
          r_out_f <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign feature_vector_output   = r_out;
  assign feature_vector_output_f = r_out_f;
  assign busy_o                  = r_busy;
  assign overrun_o               = r_overrun;

endmodule

// File: tb/tb_feature_vector_tx.sv
// tb/tb_feature_vector_tx.sv - randomized and directed bench against a frame-level model
module tb_feature_vector_tx;

  localparam int NF   = 10;
  localparam int SL   = 4;
  localparam int FL   = 42;
  localparam int GAP  = 2;
  localparam int SATV = 127;

  logic       work_clk = 1'b0;
  logic       rst_n;
  logic       aer_valid;
  logic [3:0] aer_addr;
  logic       frame_end;
  logic [6:0] feature_vector_output;
  logic       feature_vector_output_f;
  logic       busy_o;
  logic       overrun_o;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_cnt  [NF];
  int m_snap [NF];
  int m_pos;
  bit m_ovr;

  feature_vector_tx dut (
    .work_clk                (work_clk),
    .rst_n                   (rst_n),
    .aer_valid               (aer_valid),
    .aer_addr                (aer_addr),
    .frame_end               (frame_end),
    .feature_vector_output   (feature_vector_output),
    .feature_vector_output_f (feature_vector_output_f),
    .busy_o                  (busy_o),
    .overrun_o               (overrun_o)
  );

  always #5 work_clk = ~work_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_cnt[i]  = 0;
      m_snap[i] = 0;
    end
    m_pos = -1;
    m_ovr = 1'b0;
  endtask

  // m_pos: -1 idle, 0..FL-1 frame cycle, FL..FL+GAP-1 gap.
  task automatic step(input bit v, input int a, input bit fe);
    bit was_idle;
    int exp_out;
    aer_valid = v;
    aer_addr  = a[3:0];
    frame_end = fe;
    @(posedge work_clk);
    #1;
    was_idle = (m_pos < 0);
    if (m_pos >= 0) begin
      m_pos++;
      if (m_pos >= FL + GAP) m_pos = -1;
    end
    if (fe) begin
      if (was_idle) begin
        for (int i = 0; i < NF; i++) begin
          m_snap[i] = m_cnt[i];
          m_cnt[i]  = 0;
        end
        m_pos = 0;
      end else begin
        m_ovr = 1'b1;
      end
    end
    if (v && a < NF && m_cnt[a] < SATV) m_cnt[a]++;
    aer_valid = 1'b0;
    frame_end = 1'b0;
    exp_out = (m_pos >= 0 && m_pos < NF * SL) ? m_snap[m_pos / SL] : 0;
    check("output_f", 32'(feature_vector_output_f), 32'(m_pos >= 0 && m_pos < FL));
    check("output", 32'(feature_vector_output), 32'(exp_out));
    check("busy", 32'(busy_o), 32'(m_pos >= 0));
    check("overrun", 32'(overrun_o), 32'(m_ovr));
  endtask

  initial begin
    rst_n     = 1'b0;
    aer_valid = 1'b0;
    aer_addr  = '0;
    frame_end = 1'b0;
    model_reset();
    repeat (3) @(posedge work_clk);
    #1;
    check("rst_output", 32'(feature_vector_output), 0);
    check("rst_output_f", 32'(feature_vector_output_f), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    rst_n = 1'b1;
    step(0, 0, 0);

    // Basic frame: feature 0 = 3, feature 9 = 5
    repeat (3) step(1, 0, 0);
    repeat (5) step(1, 9, 0);
    step(0, 0, 1);
    check("r034_c0", 32'(feature_vector_output), 3);
    for (int c = 1; c < FL + GAP + 2; c++) begin
      step(0, 0, 0);
      if (c == 36 || c == 39) check("r034_c36_39", 32'(feature_vector_output), 5);
      if (c == 40) check("r034_tail", 32'(feature_vector_output), 0);
      if (c == 42) check("r034_gap_f", 32'(feature_vector_output_f), 0);
      if (c == 43) check("r034_gap_busy", 32'(busy_o), 1);
      if (c == 44) check("r034_idle_busy", 32'(busy_o), 0);
    end

    // Saturation
    repeat (200) step(1, 4, 0);
    step(0, 0, 1);
    for (int c = 1; c < FL + GAP + 2; c++) begin
      step(0, 0, 0);
      if (c == 16 || c == 19) check("r035_sat", 32'(feature_vector_output), SATV);
    end

    // Out-of-range addresses only
    repeat (30) step(1, ($urandom % 2) ? 10 : 15, 0);
    step(0, 0, 1);
    for (int c = 1; c < FL + GAP + 2; c++) step(0, 0, 0);

    // Overrun: second frame_end mid-frame is ignored
    repeat (20) step(1, $urandom % NF, 0);
    step(0, 0, 1);
    for (int c = 1; c < 20; c++) step($urandom % 2, $urandom % 16, 0);
    step(1, 3, 1);
    check("r037_overrun", 32'(overrun_o), 1);
    for (int c = 0; c < 30; c++) step($urandom % 2, $urandom % 16, 0);
    step(0, 0, 1);
    for (int c = 1; c < FL + GAP + 2; c++) step(0, 0, 0);

    // Event coincident with accepted frame_end goes to the new window
    step(1, 2, 1);
    for (int c = 1; c < FL + GAP + 2; c++) begin
      step(0, 0, 0);
      if (c == 8) check("r038_cur", 32'(feature_vector_output), 0);
    end
    step(0, 0, 1);
    for (int c = 1; c < FL + GAP + 2; c++) begin
      step(0, 0, 0);
      if (c == 8) check("r038_next", 32'(feature_vector_output), 1);
    end

    // Asynchronous reset mid-frame
    repeat (10) step(1, $urandom % NF, 0);
    step(0, 0, 1);
    repeat (10) step(1, $urandom % NF, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("r039_output_f", 32'(feature_vector_output_f), 0);
    check("r039_output", 32'(feature_vector_output), 0);
    check("r039_busy", 32'(busy_o), 0);
    check("r039_overrun", 32'(overrun_o), 0);
    model_reset();
    @(posedge work_clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) step(0, 0, 0);

    // Random traffic with sporadic frame_end pulses
    for (int c = 0; c < 3000; c++) begin
      step($urandom % 2, $urandom % 16, ($urandom % 50) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
